// File: rtl/key_step_conditioner_pkg.sv
// Shared constants for the key step conditioner: parameter defaults and
// synchronizer reset levels (key idles released-high, data idles low).
package key_step_conditioner_pkg;

    localparam int DEBOUNCE_DEFAULT   = 500000;
    localparam int CNT_W_DEFAULT      = 20;
    localparam int STEP_CNT_W_DEFAULT = 8;

    localparam logic KEY_SYNC_RST = 1'b1;
    localparam logic W_SYNC_RST   = 1'b0;

endpackage

// File: rtl/key_step_conditioner_sync2.sv
// Two-flop synchronizer with a synchronous reset to a parameterised level,
// used to bring the asynchronous key and data switch into the clk domain.
module key_step_conditioner_sync2
    import key_step_conditioner_pkg::*;
#(
    parameter logic RESET_VAL = W_SYNC_RST
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge, giving a true 2-stage delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_step_conditioner.sv
// Debounces a bouncing active-low key into a one-cycle step strobe, captures
// the synchronised data bit on each accepted press and counts the presses.
module key_step_conditioner
    import key_step_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int STEP_CNT_W      = STEP_CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  key_n,
    input  logic                  w_raw,
    output logic                  step,
    output logic                  w,
    output logic                  key_level,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic key_s;
    logic w_s;

    key_step_conditioner_sync2 #(.RESET_VAL(KEY_SYNC_RST)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (key_n),
        .q_o   (key_s)
    );

    key_step_conditioner_sync2 #(.RESET_VAL(W_SYNC_RST)) u_w_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (w_raw),
        .q_o   (w_s)
    );

    logic                  key_db_q,     key_db_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  step_q,       step_d;
    logic                  w_q,          w_d;
    logic [STEP_CNT_W-1:0] step_count_q, step_count_d;
    logic                  accept;
    logic                  press_accept;

    // NOTE: every signal gets a default before the if/else so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        key_db_d     = key_db_q;
        cnt_d        = '0;
        accept       = 1'b0;
        press_accept = 1'b0;
        w_d          = w_q;
        step_count_d = step_count_q;

        if (key_s != key_db_q) begin
            if (cnt_q == CNT_LAST) begin
                accept   = 1'b1;
                key_db_d = key_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Only the released-to-pressed transition (raw level going low) steps.
        press_accept = accept && !key_s;
        step_d       = press_accept;
        if (press_accept) begin
            w_d          = w_s;
            step_count_d = step_count_q + STEP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_db_q     <= KEY_SYNC_RST;
            cnt_q        <= '0;
            step_q       <= 1'b0;
            w_q          <= 1'b0;
            step_count_q <= '0;
        end else begin
            key_db_q     <= key_db_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            w_q          <= w_d;
            step_count_q <= step_count_d;
        end
    end

    assign step       = step_q;
    assign w          = w_q;
    assign key_level  = ~key_db_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_key_step_conditioner.sv
// Self-checking bench: a window-based behavioural model of the debounce rules
// is compared every cycle, plus literal expectations for the directed scenarios.
module tb_key_step_conditioner;

    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic       key_n;
    logic       w_raw;
    logic       step;
    logic       w;
    logic       key_level;
    logic [7:0] step_count;

    int n_checks = 0;
    int n_pass   = 0;

    key_step_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (3),
        .STEP_CNT_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .w_raw      (w_raw),
        .step       (step),
        .w          (w),
        .key_level  (key_level),
        .step_count (step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: inputs reach the debouncer two edges late; a level is
    // accepted once the last D synchronised samples all differ from the
    // accepted level.
    logic       mk1, mk2, mw1, mw2;
    logic       m_acc;
    logic       m_step;
    logic       m_w;
    logic [7:0] m_cnt;
    logic       hist[$];
    logic       ks, ws, all_diff;
    bit         started = 0;

    always @(posedge clk) begin
        if (reset) begin
            mk1 = 1'b1; mk2 = 1'b1; mw1 = 1'b0; mw2 = 1'b0;
            hist.delete();
            m_acc = 1'b1; m_step = 1'b0; m_w = 1'b0; m_cnt = 8'd0;
        end else begin
            ks = mk2;
            ws = mw2;
            hist.push_back(ks);
            if (hist.size() > D) void'(hist.pop_front());
            all_diff = (hist.size() == D);
            foreach (hist[i]) if (hist[i] == m_acc) all_diff = 1'b0;
            m_step = all_diff && !ks;
            if (all_diff) m_acc = ks;
            if (m_step) begin
                m_w   = ws;
                m_cnt = m_cnt + 8'd1;
            end
            mk2 = mk1; mk1 = key_n;
            mw2 = mw1; mw1 = w_raw;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_step",       {31'd0, step},      {31'd0, m_step});
            check("model_w",          {31'd0, w},         {31'd0, m_w});
            check("model_key_level",  {31'd0, key_level}, {31'd0, ~m_acc});
            check("model_step_count", {24'd0, step_count}, {24'd0, m_cnt});
        end
    end

    // Runs n cycles from a negedge; counts step pulses and the first pulse's index.
    task automatic run(input int n, output int pulses, output int first);
        pulses = 0;
        first  = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (step === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    int p, f, total;

    initial begin
        reset = 1'b1;
        key_n = 1'b0;
        w_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_step",       {31'd0, step},       32'd0);
            check("reset_w",          {31'd0, w},          32'd0);
            check("reset_key_level",  {31'd0, key_level},  32'd0);
            check("reset_step_count", {24'd0, step_count}, 32'd0);
        end
        reset = 1'b0;
        key_n = 1'b1;
        run(10, p, f);
        check("idle_no_step", p, 0);

        // Clean press
        key_n = 1'b0; w_raw = 1'b1;
        run(20, p, f);
        check("press_pulses", p, 1);
        check("press_latency_in_window", {31'd0, (f >= 1 + D) && (f <= 3 + D)}, 32'd1);
        check("press_w", {31'd0, w}, 32'd1);
        check("press_count", {24'd0, step_count}, 32'd1);
        check("press_key_level", {31'd0, key_level}, 32'd1);

        // Bounce
        key_n = 1'b1;
        run(10, p, f);
        check("release_no_step", p, 0);
        check("release_key_level", {31'd0, key_level}, 32'd0);
        total = 0;
        for (int k = 0; k < 6; k++) begin
            key_n = k[0];
            run(2, p, f);
            total += p;
        end
        check("bounce_no_step", total, 0);
        key_n = 1'b0;
        run(20, p, f);
        check("bounce_settle_pulses", p, 1);
        check("bounce_count", {24'd0, step_count}, 32'd2);

        // Release, then re-press with w_raw low
        key_n = 1'b1; w_raw = 1'b0;
        run(12, p, f);
        check("release2_no_step", p, 0);
        key_n = 1'b0;
        run(12, p, f);
        check("press_w0_pulses", p, 1);
        check("press_w0_w", {31'd0, w}, 32'd0);
        check("press_w0_count", {24'd0, step_count}, 32'd3);
        run(5, p, f);
        check("held_no_repeat", p, 0);
        check("held_w_stays", {31'd0, w}, 32'd0);

        // 256 clean presses wrap the counter back to where it started
        total = 0;
        for (int k = 0; k < 256; k++) begin
            key_n = 1'b1;
            w_raw = 1'($urandom);
            run(8, p, f);
            total += p;
            key_n = 1'b0;
            run(8, p, f);
            total += p;
        end
        check("wrap_pulses", total, 256);
        check("wrap_count", {24'd0, step_count}, 32'd3);

        // Reset mid-debounce with the key held through reset release
        key_n = 1'b1;
        run(10, p, f);
        key_n = 1'b0;
        run(2, p, f);
        check("pre_reset_no_step", p, 0);
        reset = 1'b1;
        run(2, p, f);
        check("in_reset_no_step", p, 0);
        reset = 1'b0;
        run(20, p, f);
        check("post_reset_pulses", p, 1);
        check("post_reset_latency_in_window", {31'd0, (f >= 1 + D) && (f <= 3 + D)}, 32'd1);
        check("post_reset_count", {24'd0, step_count}, 32'd1);

        // Random key/data activity checked against the model
        for (int k = 0; k < 120; k++) begin
            key_n = 1'($urandom);
            w_raw = 1'($urandom);
            run($urandom_range(1, 8), p, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
